// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : trap_ctrl_pkg                                                    |
// | Purpose : Shared definitions for the M-mode trap controller: cause codes,  |
// |           mstatus bit positions, exception priority order, FSM encodings.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package trap_ctrl_pkg;

  // Width of the cause code (holds any bit index of a 64-bit mip).
  localparam int CAUSE_W = 6;

  // Synchronous exception cause codes
  localparam int EXC_INST_MISALIGNED  = 0;
  localparam int EXC_INST_FAULT       = 1;
  localparam int EXC_ILLEGAL_INST     = 2;
  localparam int EXC_BREAKPOINT       = 3;
  localparam int EXC_LOAD_MISALIGNED  = 4;
  localparam int EXC_LOAD_FAULT       = 5;
  localparam int EXC_STORE_MISALIGNED = 6;
  localparam int EXC_STORE_FAULT      = 7;
  localparam int EXC_ECALL_U          = 8;
  localparam int EXC_ECALL_S          = 9;
  localparam int EXC_ECALL_M          = 11;
  localparam int EXC_INST_PAGE        = 12;
  localparam int EXC_LOAD_PAGE        = 13;
  localparam int EXC_STORE_PAGE       = 15;

  // Interrupt cause codes (also mip/mie bit positions)
  localparam int IRQ_MSI        = 3;
  localparam int IRQ_MTI        = 7;
  localparam int IRQ_MEI        = 11;
  localparam int IRQ_LOCAL_BASE = 16;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Exception priority, highest first; unlisted bits follow lowest-first.
  localparam int EXC_PRIO_N = 14;
  localparam int EXC_PRIO [0:EXC_PRIO_N-1] = '{
    EXC_INST_PAGE, EXC_INST_FAULT, EXC_INST_MISALIGNED, EXC_ILLEGAL_INST,
    EXC_BREAKPOINT, EXC_ECALL_U, EXC_ECALL_S, EXC_ECALL_M,
    EXC_STORE_MISALIGNED, EXC_LOAD_MISALIGNED, EXC_STORE_PAGE,
    EXC_LOAD_PAGE, EXC_STORE_FAULT, EXC_LOAD_FAULT
  };

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_MRET_WR = 3'd3,
    ST_REDIR   = 3'd4
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_IRQ  = 2'd1,
    KIND_MRET = 2'd2
  } trap_kind_e;

  function automatic logic exc_in_prio_list(input int c);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < EXC_PRIO_N; k++) begin
      if (EXC_PRIO[k] == c) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : trap_prio_enc                                                    |
// | Purpose : Combinational priority selection of the interrupt cause and the  |
// |           synchronous exception cause at the commit point.                 |
// | Ports   : irq_pend  (in)  enabled pending interrupts (mip & mie)           |
// |           excp      (in)  exception bits of the committing instruction     |
// |           irq_valid/irq_cause (out) any interrupt / winning cause          |
// |           exc_valid/exc_cause (out) any exception / winning cause          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module trap_prio_enc import trap_ctrl_pkg::*; #(
  parameter int XLEN   = 64,
  parameter int EXCP_W = 16,
  parameter int NLOCAL = 4
) (
  input  logic [XLEN-1:0]    irq_pend,
  input  logic [EXCP_W-1:0]  excp,
  output logic               irq_valid,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic               exc_valid,
  output logic [CAUSE_W-1:0] exc_cause
);

  // Each stage overwrites the previous one, so the last assignment that hits
  // is the highest priority: scan from lowest priority upward.
  always_comb begin
    irq_valid = |irq_pend;
    irq_cause = '0;
    // Non-standard pending bits: lowest index wins, only if nothing below hits.
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_cause = CAUSE_W'(i);
    end
    for (int i = NLOCAL - 1; i >= 0; i--) begin
      if (irq_pend[IRQ_LOCAL_BASE + i]) irq_cause = CAUSE_W'(IRQ_LOCAL_BASE + i);
    end
    if (irq_pend[IRQ_MTI]) irq_cause = CAUSE_W'(IRQ_MTI);
    if (irq_pend[IRQ_MSI]) irq_cause = CAUSE_W'(IRQ_MSI);
    if (irq_pend[IRQ_MEI]) irq_cause = CAUSE_W'(IRQ_MEI);
  end

  always_comb begin
    exc_valid = |excp;
    exc_cause = '0;
    for (int i = EXCP_W - 1; i >= 0; i--) begin
      if (excp[i] && !exc_in_prio_list(i)) exc_cause = CAUSE_W'(i);
    end
    for (int k = EXC_PRIO_N - 1; k >= 0; k--) begin
      if (EXC_PRIO[k] < EXCP_W) begin
        if (excp[EXC_PRIO[k]]) exc_cause = CAUSE_W'(EXC_PRIO[k]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : trap_ctrl                                                        |
// | Purpose : Sequential M-mode trap controller at the commit point. Accepts   |
// |           an interrupt, exception or mret, then runs flush -> CSR write -> |
// |           redirect with the pipeline. Supports vectored mtvec.             |
// | Ports   : commit_*        (in)  committing instruction info                |
// |           mem_addr        (in)  faulting load/store address                |
// |           *_rd            (in)  CSR read data                              |
// |           commit_kill     (out) suppress this commit (comb.)               |
// |           trap_busy       (out) sequence in progress                       |
// |           flush_req/ack         pipeline drain handshake                   |
// |           csr_wr_en, mstatus_wr_en, *_wd (out) CSR write pulses/data       |
// |           redirect_valid/pc (out) fetch redirect pulse and target          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module trap_ctrl import trap_ctrl_pkg::*; #(
  parameter int XLEN   = 64,
  parameter int EXCP_W = 16,
  parameter int NLOCAL = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              commit_valid,
  input  logic [EXCP_W-1:0] commit_excp,
  input  logic              commit_is_mret,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic [31:0]       commit_inst,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mstatus_rd,
  input  logic [XLEN-1:0]   mie_rd,
  input  logic [XLEN-1:0]   mip_rd,
  input  logic [XLEN-1:0]   mtvec_rd,
  input  logic [XLEN-1:0]   mepc_rd,
  output logic              commit_kill,
  output logic              trap_busy,
  output logic              flush_req,
  input  logic              flush_ack,
  output logic              csr_wr_en,
  output logic              mstatus_wr_en,
  output logic [XLEN-1:0]   mcause_wd,
  output logic [XLEN-1:0]   mepc_wd,
  output logic [XLEN-1:0]   mtval_wd,
  output logic [XLEN-1:0]   mstatus_wd,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  trap_state_e        state;
  trap_kind_e         kind;
  logic [CAUSE_W-1:0] cause;
  logic [XLEN-1:0]    epc;
  logic [XLEN-1:0]    tval;

  logic               irq_valid, exc_valid, take_irq, accept;
  logic [CAUSE_W-1:0] irq_cause, exc_cause;
  trap_kind_e         acc_kind;
  logic [CAUSE_W-1:0] acc_cause;
  logic [XLEN-1:0]    acc_tval;
  logic [XLEN-1:0]    mcause_val, ms_trap, ms_mret, tvec_base, redir_target;

  trap_prio_enc #(
    .XLEN   (XLEN),
    .EXCP_W (EXCP_W),
    .NLOCAL (NLOCAL)
  ) u_prio_enc (
    .irq_pend  (mip_rd & mie_rd),
    .excp      (commit_excp),
    .irq_valid (irq_valid),
    .irq_cause (irq_cause),
    .exc_valid (exc_valid),
    .exc_cause (exc_cause)
  );

  assign take_irq    = irq_valid && mstatus_rd[MSTATUS_MIE];
  assign accept      = (state == ST_IDLE) && commit_valid &&
                       (take_irq || exc_valid || commit_is_mret);
  // Reset gating keeps the kill low while reset is asserted.
  assign commit_kill = reset_n && accept;
  assign trap_busy   = (state != ST_IDLE);

  // What gets latched on accept: kind, cause and the trap value.
  always_comb begin
    acc_kind  = KIND_MRET;
    acc_cause = '0;
    acc_tval  = '0;
    if (take_irq) begin
      acc_kind  = KIND_IRQ;
      acc_cause = irq_cause;
    end else if (exc_valid) begin
      acc_kind  = KIND_EXC;
      acc_cause = exc_cause;
      case (exc_cause)
        CAUSE_W'(EXC_INST_MISALIGNED), CAUSE_W'(EXC_INST_FAULT),
        CAUSE_W'(EXC_BREAKPOINT),      CAUSE_W'(EXC_INST_PAGE):
          acc_tval = commit_pc;
        CAUSE_W'(EXC_ILLEGAL_INST):
          acc_tval = XLEN'(commit_inst);
        CAUSE_W'(EXC_LOAD_MISALIGNED), CAUSE_W'(EXC_LOAD_FAULT),
        CAUSE_W'(EXC_STORE_MISALIGNED), CAUSE_W'(EXC_STORE_FAULT),
        CAUSE_W'(EXC_LOAD_PAGE),       CAUSE_W'(EXC_STORE_PAGE):
          acc_tval = mem_addr;
        default:
          acc_tval = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      kind           <= KIND_EXC;
      cause          <= '0;
      epc            <= '0;
      tval           <= '0;
      flush_req      <= 1'b0;
      csr_wr_en      <= 1'b0;
      mstatus_wr_en  <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      csr_wr_en      <= 1'b0;
      mstatus_wr_en  <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            kind      <= acc_kind;
            cause     <= acc_cause;
            epc       <= {commit_pc[XLEN-1:1], 1'b0};
            tval      <= acc_tval;
            flush_req <= 1'b1;
            state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_ack) begin
            flush_req <= 1'b0;
            if (kind == KIND_MRET) begin
              mstatus_wr_en <= 1'b1;
              state         <= ST_MRET_WR;
            end else begin
              csr_wr_en <= 1'b1;
              state     <= ST_WRITE;
            end
          end
        end
        ST_WRITE, ST_MRET_WR: begin
          redirect_valid <= 1'b1;
          state          <= ST_REDIR;
        end
        ST_REDIR: state <= ST_IDLE;
        default: begin
          flush_req <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mcause_val                 = '0;
    mcause_val[CAUSE_W-1:0]    = cause;
    mcause_val[XLEN-1]         = (kind == KIND_IRQ);

    ms_trap                    = mstatus_rd;
    ms_trap[MSTATUS_MPIE]      = mstatus_rd[MSTATUS_MIE];
    ms_trap[MSTATUS_MIE]       = 1'b0;
    ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    ms_mret                    = mstatus_rd;
    ms_mret[MSTATUS_MIE]       = mstatus_rd[MSTATUS_MPIE];
    ms_mret[MSTATUS_MPIE]      = 1'b1;
    ms_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    // Modes 2/3 fall back to direct; only mode 1 vectors, and only interrupts.
    tvec_base = {mtvec_rd[XLEN-1:2], 2'b00};
    if (kind == KIND_MRET)
      redir_target = mepc_rd;
    else if (kind == KIND_IRQ && mtvec_rd[1:0] == 2'b01)
      redir_target = tvec_base + (XLEN'(cause) << 2);
    else
      redir_target = tvec_base;
  end

  // Write data and target are only driven alongside their strobes.
  assign mcause_wd   = csr_wr_en ? mcause_val : '0;
  assign mepc_wd     = csr_wr_en ? epc : '0;
  assign mtval_wd    = csr_wr_en ? tval : '0;
  assign mstatus_wd  = csr_wr_en ? ms_trap : (mstatus_wr_en ? ms_mret : '0);
  assign redirect_pc = redirect_valid ? redir_target : '0;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_trap_ctrl                                                     |
// | Purpose : Self-checking bench for trap_ctrl: directed scenarios plus       |
// |           randomized commits checked against a behavioural model.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_trap_ctrl;
  localparam int XLEN = 64;
  localparam int EXCP_W = 16;
  localparam int NLOCAL = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              commit_valid, commit_is_mret, flush_ack;
  logic [EXCP_W-1:0] commit_excp;
  logic [XLEN-1:0]   commit_pc, mem_addr, mstatus_rd, mie_rd, mip_rd, mtvec_rd, mepc_rd;
  logic [31:0]       commit_inst;
  logic              commit_kill, trap_busy, flush_req, csr_wr_en, mstatus_wr_en, redirect_valid;
  logic [XLEN-1:0]   mcause_wd, mepc_wd, mtval_wd, mstatus_wd, redirect_pc;

  trap_ctrl #(.XLEN(XLEN), .EXCP_W(EXCP_W), .NLOCAL(NLOCAL)) dut (
    .clock(clock), .reset_n(reset_n), .commit_valid(commit_valid),
    .commit_excp(commit_excp), .commit_is_mret(commit_is_mret),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .mem_addr(mem_addr),
    .mstatus_rd(mstatus_rd), .mie_rd(mie_rd), .mip_rd(mip_rd),
    .mtvec_rd(mtvec_rd), .mepc_rd(mepc_rd), .commit_kill(commit_kill),
    .trap_busy(trap_busy), .flush_req(flush_req), .flush_ack(flush_ack),
    .csr_wr_en(csr_wr_en), .mstatus_wr_en(mstatus_wr_en),
    .mcause_wd(mcause_wd), .mepc_wd(mepc_wd), .mtval_wd(mtval_wd),
    .mstatus_wd(mstatus_wd), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  // Observations of one transaction
  logic            obs_kill, obs_busy_after, obs_timeout;
  int              obs_flush_cycles, obs_csr_pulses, obs_ms_pulses, obs_redir_cycle;
  logic [XLEN-1:0] obs_mcause, obs_mepc, obs_mtval, obs_mstatus, obs_rpc;

  typedef struct {
    bit              accept;
    bit              is_mret;
    logic [XLEN-1:0] mcause, mepc, mtval, mstatus, rpc;
  } exp_t;

  // Behavioural model from the architectural trap rules.
  function automatic exp_t ref_model();
    exp_t e;
    int irq_order [7] = '{11, 3, 7, 16, 17, 18, 19};
    int exc_order [16] = '{12, 1, 0, 2, 3, 8, 9, 11, 6, 4, 15, 13, 7, 5, 10, 14};
    logic [XLEN-1:0] pend;
    int c;
    bit irq, found;
    e = '{default: '0};
    pend = mip_rd & mie_rd;
    irq = (mstatus_rd[3] == 1'b1) && (pend != 0);
    c = 0;
    found = 0;
    if (irq) begin
      foreach (irq_order[k]) if (!found && pend[irq_order[k]]) begin c = irq_order[k]; found = 1; end
      for (int i = 0; i < XLEN; i++) if (!found && pend[i]) begin c = i; found = 1; end
    end else if (commit_excp != 0) begin
      foreach (exc_order[k]) if (!found && commit_excp[exc_order[k]]) begin c = exc_order[k]; found = 1; end
    end
    e.accept = irq || (commit_excp != 0) || commit_is_mret;
    e.is_mret = !irq && (commit_excp == 0) && commit_is_mret;
    e.mcause = irq ? ((64'd1 << 63) | 64'(c)) : 64'(c);
    e.mepc = commit_pc & ~64'd1;
    if (irq) e.mtval = 0;
    else if (c == 0 || c == 1 || c == 3 || c == 12) e.mtval = commit_pc;
    else if (c == 2) e.mtval = {32'd0, commit_inst};
    else if ((c >= 4 && c <= 7) || c == 13 || c == 15) e.mtval = mem_addr;
    else e.mtval = 0;
    e.mstatus = mstatus_rd;
    if (e.is_mret) begin
      e.mstatus[3] = mstatus_rd[7];
      e.mstatus[7] = 1'b1;
    end else begin
      e.mstatus[7] = mstatus_rd[3];
      e.mstatus[3] = 1'b0;
    end
    e.mstatus[12:11] = 2'b11;
    if (e.is_mret) e.rpc = mepc_rd;
    else if (irq && mtvec_rd[1:0] == 2'b01) e.rpc = (mtvec_rd & ~64'd3) + 64'(4 * c);
    else e.rpc = mtvec_rd & ~64'd3;
    return e;
  endfunction

  // Drives one commit and records what the DUT does (no comparisons here).
  task automatic do_txn(input int ack_delay);
    int fidx;
    obs_flush_cycles = 0; obs_csr_pulses = 0; obs_ms_pulses = 0; obs_redir_cycle = -1;
    obs_mcause = 0; obs_mepc = 0; obs_mtval = 0; obs_mstatus = 0; obs_rpc = 0; obs_timeout = 0;
    @(negedge clock);
    commit_valid = 1'b1;
    #1 obs_kill = commit_kill;
    @(posedge clock);
    #1 commit_valid = 1'b0;
    if (obs_kill) begin
      fidx = 0;
      for (int cyc = 1; cyc <= 40 && obs_redir_cycle < 0; cyc++) begin
        @(negedge clock);
        if (flush_req) begin
          obs_flush_cycles++;
          flush_ack = (fidx == ack_delay);
          fidx++;
        end else begin
          flush_ack = 1'($urandom_range(0, 1));
        end
        if (csr_wr_en) begin
          obs_csr_pulses++;
          obs_mcause = mcause_wd; obs_mepc = mepc_wd; obs_mtval = mtval_wd; obs_mstatus = mstatus_wd;
        end
        if (mstatus_wr_en) begin obs_ms_pulses++; obs_mstatus = mstatus_wd; end
        if (redirect_valid) begin obs_redir_cycle = cyc; obs_rpc = redirect_pc; end
      end
      if (obs_redir_cycle < 0) obs_timeout = 1'b1;
    end
    @(negedge clock);
    flush_ack = 1'b0;
    obs_busy_after = trap_busy;
  endtask

  task automatic clear_inputs();
    commit_valid = 0; commit_is_mret = 0; commit_excp = 0; flush_ack = 0;
    commit_pc = 0; commit_inst = 0; mem_addr = 0;
    mstatus_rd = 0; mie_rd = 0; mip_rd = 0; mtvec_rd = 0; mepc_rd = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({commit_kill, trap_busy, flush_req, csr_wr_en, mstatus_wr_en, redirect_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {commit_kill, trap_busy, flush_req, csr_wr_en, mstatus_wr_en, redirect_valid});
    end
    n_cmp++;
    if ((mcause_wd | mepc_wd | mtval_wd | mstatus_wd | redirect_pc) !== 64'd0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", mcause_wd | mepc_wd | mtval_wd | mstatus_wd | redirect_pc);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (trap_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", trap_busy); end
  endtask

  task automatic test_irq_vectored();
    clear_inputs();
    mip_rd = 64'h888; mie_rd = 64'h888; mstatus_rd = 64'h8;
    commit_pc = 64'h8000_0010; mtvec_rd = 64'h8000_0101;
    do_txn(0);
    n_cmp++; if (obs_kill !== 1'b1) begin n_fail++; $display("FAIL irq_kill: got %b want 1", obs_kill); end
    n_cmp++; if (obs_mcause !== 64'h8000_0000_0000_000B) begin n_fail++; $display("FAIL irq_mcause: got %h want 800000000000000b", obs_mcause); end
    n_cmp++; if (obs_mepc !== 64'h8000_0010) begin n_fail++; $display("FAIL irq_mepc: got %h want 80000010", obs_mepc); end
    n_cmp++; if (obs_rpc !== 64'h8000_012C) begin n_fail++; $display("FAIL irq_rpc: got %h want 8000012c", obs_rpc); end
    n_cmp++; if (obs_redir_cycle != 3) begin n_fail++; $display("FAIL irq_latency: got %0d want 3", obs_redir_cycle); end
    n_cmp++; if (obs_mtval !== 64'd0) begin n_fail++; $display("FAIL irq_mtval: got %h want 0", obs_mtval); end
  endtask

  task automatic test_exc_priority();
    clear_inputs();
    commit_excp = 16'h1004; commit_pc = 64'h100; commit_inst = 32'hFFFF_FFFF; mstatus_rd = 64'h8;
    mtvec_rd = 64'h4000;
    do_txn(0);
    n_cmp++; if (obs_mcause !== 64'd12) begin n_fail++; $display("FAIL exc_mcause: got %h want c", obs_mcause); end
    n_cmp++; if (obs_mtval !== 64'h100) begin n_fail++; $display("FAIL exc_mtval: got %h want 100", obs_mtval); end
    n_cmp++; if (obs_mstatus !== 64'h1880) begin n_fail++; $display("FAIL exc_mstatus: got %h want 1880", obs_mstatus); end
    n_cmp++; if (obs_rpc !== 64'h4000) begin n_fail++; $display("FAIL exc_rpc: got %h want 4000", obs_rpc); end
  endtask

  task automatic test_delayed_ack();
    clear_inputs();
    commit_excp = 16'h0020; mem_addr = 64'hDEAD_BEEF; commit_pc = 64'h200; mtvec_rd = 64'h3000;
    do_txn(5);
    n_cmp++; if (obs_flush_cycles != 6) begin n_fail++; $display("FAIL dly_flush_cycles: got %0d want 6", obs_flush_cycles); end
    n_cmp++; if (obs_csr_pulses != 1) begin n_fail++; $display("FAIL dly_csr_pulses: got %0d want 1", obs_csr_pulses); end
    n_cmp++; if (obs_mtval !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL dly_mtval: got %h want deadbeef", obs_mtval); end
    n_cmp++; if (obs_mcause !== 64'd5) begin n_fail++; $display("FAIL dly_mcause: got %h want 5", obs_mcause); end
    n_cmp++; if (obs_redir_cycle != 8) begin n_fail++; $display("FAIL dly_latency: got %0d want 8", obs_redir_cycle); end
  endtask

  task automatic test_mret();
    clear_inputs();
    commit_is_mret = 1; mstatus_rd = 64'h80; mepc_rd = 64'h2000; mtvec_rd = 64'h5000;
    do_txn(0);
    n_cmp++; if (obs_ms_pulses != 1) begin n_fail++; $display("FAIL mret_ms_pulses: got %0d want 1", obs_ms_pulses); end
    n_cmp++; if (obs_csr_pulses != 0) begin n_fail++; $display("FAIL mret_csr_pulses: got %0d want 0", obs_csr_pulses); end
    n_cmp++; if (obs_mstatus !== 64'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h want 1888", obs_mstatus); end
    n_cmp++; if (obs_rpc !== 64'h2000) begin n_fail++; $display("FAIL mret_rpc: got %h want 2000", obs_rpc); end
  endtask

  task automatic test_masked_irq_ecall();
    clear_inputs();
    mip_rd = 64'h80; mie_rd = 64'h80; mstatus_rd = 64'h0; commit_excp = 16'h0800;
    commit_pc = 64'h1234; mtvec_rd = 64'h8000_0101;
    do_txn(1);
    n_cmp++; if (obs_mcause !== 64'd11) begin n_fail++; $display("FAIL mask_mcause: got %h want b", obs_mcause); end
    n_cmp++; if (obs_rpc !== 64'h8000_0100) begin n_fail++; $display("FAIL mask_rpc: got %h want 80000100", obs_rpc); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    commit_excp = 16'h0800; commit_pc = 64'h40; mtvec_rd = 64'h600;
    @(negedge clock); commit_valid = 1;
    @(posedge clock); #1 commit_valid = 0;
    @(negedge clock); flush_ack = 1;
    @(negedge clock); flush_ack = 0;
    n_cmp++; if (csr_wr_en !== 1'b1) begin n_fail++; $display("FAIL rmid_in_write: got %b want 1", csr_wr_en); end
    reset_n = 0; commit_valid = 1;
    #1;
    n_cmp++;
    if ({commit_kill, trap_busy, flush_req, csr_wr_en, mstatus_wr_en, redirect_valid} !== 6'b0) begin
      n_fail++; $display("FAIL rmid_ctrl: got %b want 000000",
        {commit_kill, trap_busy, flush_req, csr_wr_en, mstatus_wr_en, redirect_valid});
    end
    n_cmp++;
    if ((mcause_wd | mepc_wd | mtval_wd | mstatus_wd | redirect_pc) !== 64'd0) begin
      n_fail++; $display("FAIL rmid_data: got %h want 0", mcause_wd | mepc_wd | mtval_wd | mstatus_wd | redirect_pc);
    end
    repeat (2) @(negedge clock);
    commit_valid = 0; reset_n = 1;
    @(negedge clock);
    n_cmp++; if (trap_busy !== 1'b0 || csr_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got busy=%b wr=%b want 0 0", trap_busy, csr_wr_en); end
    do_txn(0);
    n_cmp++; if (obs_mcause !== 64'd11) begin n_fail++; $display("FAIL rmid_next_mcause: got %h want b", obs_mcause); end
    n_cmp++; if (obs_rpc !== 64'h600 || obs_redir_cycle != 3) begin n_fail++; $display("FAIL rmid_next_redir: got %h@%0d want 600@3", obs_rpc, obs_redir_cycle); end
  endtask

  task automatic test_random();
    exp_t e;
    int dly;
    for (int it = 0; it < 60; it++) begin
      clear_inputs();
      mstatus_rd = {$urandom, $urandom};
      mip_rd = {$urandom, $urandom} & 64'h000F_0888;
      mie_rd = {$urandom, $urandom} & 64'h000F_0888;
      commit_excp = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      commit_is_mret = 1'($urandom_range(0, 1));
      commit_pc = {$urandom, $urandom};
      commit_inst = $urandom;
      mem_addr = {$urandom, $urandom};
      mtvec_rd = {$urandom, $urandom};
      mepc_rd = {$urandom, $urandom};
      dly = $urandom_range(0, 3);
      e = ref_model();
      do_txn(dly);
      n_cmp++; if (obs_kill !== e.accept) begin n_fail++; $display("FAIL rnd_kill[%0d]: got %b want %b", it, obs_kill, e.accept); end
      n_cmp++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_after[%0d]: got %b want 0", it, obs_busy_after); end
      if (e.accept && obs_kill) begin
        n_cmp++; if (obs_timeout || obs_redir_cycle != 3 + dly) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, obs_redir_cycle, 3 + dly); end
        n_cmp++; if (obs_rpc !== e.rpc) begin n_fail++; $display("FAIL rnd_rpc[%0d]: got %h want %h", it, obs_rpc, e.rpc); end
        n_cmp++; if (obs_mstatus !== e.mstatus) begin n_fail++; $display("FAIL rnd_mstatus[%0d]: got %h want %h", it, obs_mstatus, e.mstatus); end
        if (e.is_mret) begin
          n_cmp++; if (obs_csr_pulses != 0 || obs_ms_pulses != 1) begin n_fail++; $display("FAIL rnd_mret_pulses[%0d]: got csr=%0d ms=%0d want 0 1", it, obs_csr_pulses, obs_ms_pulses); end
        end else begin
          n_cmp++; if (obs_csr_pulses != 1 || obs_ms_pulses != 0) begin n_fail++; $display("FAIL rnd_trap_pulses[%0d]: got csr=%0d ms=%0d want 1 0", it, obs_csr_pulses, obs_ms_pulses); end
          n_cmp++; if (obs_mcause !== e.mcause) begin n_fail++; $display("FAIL rnd_mcause[%0d]: got %h want %h", it, obs_mcause, e.mcause); end
          n_cmp++; if (obs_mepc !== e.mepc) begin n_fail++; $display("FAIL rnd_mepc[%0d]: got %h want %h", it, obs_mepc, e.mepc); end
          n_cmp++; if (obs_mtval !== e.mtval) begin n_fail++; $display("FAIL rnd_mtval[%0d]: got %h want %h", it, obs_mtval, e.mtval); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_irq_vectored();
    test_exc_priority();
    test_delayed_ack();
    test_mret();
    test_masked_irq_ecall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
